// File: rtl/cordic_hyp_rsp_queue_if.sv
// Request/response handshake bundle for cordic_hyp_rsp_queue.
// The master drives requests and accepts responses; the slave is the queue.
interface cordic_hyp_rsp_queue_if #(parameter int W = 12);
    logic           req_valid;
    logic           req_ready;
    logic           req_func;
    logic [2*W-1:0] req_a;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_f;
    logic           rsp_func;

    modport master (
        output req_valid, req_func, req_a, rsp_ready,
        input  req_ready, rsp_valid, rsp_f, rsp_func
    );

    modport slave (
        input  req_valid, req_func, req_a, rsp_ready,
        output req_ready, rsp_valid, rsp_f, rsp_func
    );
endinterface

// File: rtl/cordic_hyp_rsp_queue.sv
// Flow-control shell around cordic_hyp: reserves a result slot per issued op so results never drop.
// Optional CORDIC_RSP_QUEUE_STATS_EN adds saturating stat_issued / stat_stall counters.
module cordic_hyp_rsp_queue #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cordic_hyp_rsp_queue_if.slave bus,
    output logic                 core_start,
    output logic                 core_func,
    output logic [2*W-1:0]       core_a,
    input  logic                 core_valid,
    input  logic [2*W-1:0]       core_f,
    output logic                 err
`ifdef CORDIC_RSP_QUEUE_STATS_EN
    ,
    output logic [15:0]          stat_issued,
    output logic [15:0]          stat_stall
`endif
);

    logic [AW:0]    tptr, dptr, rptr;
    logic [AW:0]    cnt, pend;
    logic           full, fire, cap, pop;
    logic           func_mem [DEPTH];
    logic [2*W-1:0] f_mem    [DEPTH];

    assign cnt  = tptr - rptr;
    assign pend = tptr - dptr;
    assign full = (cnt == (AW+1)'(DEPTH));

    // Readiness depends only on registered pointers, so a pop never bypasses into a full queue.
    assign bus.req_ready = !full;
    assign fire          = bus.req_valid & !full;
    assign cap           = core_valid & (pend != '0);
    assign pop           = bus.rsp_valid & bus.rsp_ready;

    assign core_start = fire;
    assign core_func  = bus.req_func;
    assign core_a     = bus.req_a;

    assign bus.rsp_valid = (dptr != rptr);
    assign bus.rsp_f     = f_mem[rptr[AW-1:0]];
    assign bus.rsp_func  = func_mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tptr <= '0;
            dptr <= '0;
            rptr <= '0;
            err  <= 1'b0;
        end else begin
            if (fire) tptr <= tptr + 1'b1;
            if (cap)  dptr <= dptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (core_valid && pend == '0) err <= 1'b1;
        end
    end

    // Slot storage is deliberately left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (fire) func_mem[tptr[AW-1:0]] <= bus.req_func;
        if (cap)  f_mem[dptr[AW-1:0]]    <= core_f;
    end

`ifdef CORDIC_RSP_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (fire && stat_issued != 16'hFFFF)
                stat_issued <= stat_issued + 16'd1;
            if (bus.req_valid && full && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cordic_hyp_rsp_queue.sv
// Randomized bench for cordic_hyp_rsp_queue with a stub core (f=a+1, W+3 cycle latency)
// and a slot-queue reference model checked every cycle.
module tb_cordic_hyp_rsp_queue;
    localparam int W     = 12;
    localparam int DW    = 2 * W;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int LAT   = W + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_start, core_func, core_valid, err;
    logic [DW-1:0] core_a, core_f;
    logic          force_cv = 1'b0;
`ifdef CORDIC_RSP_QUEUE_STATS_EN
    logic [15:0]   stat_issued, stat_stall;
`endif

    cordic_hyp_rsp_queue_if #(.W(W)) bus();

    cordic_hyp_rsp_queue #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .core_start (core_start),
        .core_func  (core_func),
        .core_a     (core_a),
        .core_valid (core_valid),
        .core_f     (core_f),
        .err        (err)
`ifdef CORDIC_RSP_QUEUE_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Stub core: fixed-latency delay line sharing the queue's reset.
    logic [LAT-1:0] v_sr;
    logic [DW-1:0]  a_sr [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            for (int i = 0; i < LAT; i++) a_sr[i] <= '0;
        end else begin
            v_sr <= {v_sr[LAT-2:0], core_start};
            a_sr[0] <= core_a;
            for (int i = 1; i < LAT; i++) a_sr[i] <= a_sr[i-1];
        end
    end
    assign core_valid = v_sr[LAT-1] | force_cv;
    assign core_f     = a_sr[LAT-1] + 1'b1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: queue of reserved slots in issue order, each with the result the stub must return.
    typedef struct { logic func; logic [DW-1:0] f; } ent_t;
    ent_t mq[$];
    int   ncap = 0;
    bit   err_m = 0;
    int   n_start = 0;
    int   st_iss = 0, st_stl = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            ncap = 0; err_m = 0; st_iss = 0; st_stl = 0;
        end else begin
            bit full_m, fire_m, cap_m, pop_m, bad_m;
            full_m = (mq.size() == DEPTH);
            chk("req_ready", 32'(bus.req_ready), 32'(!full_m));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(ncap > 0));
            chk("core_start", 32'(core_start), 32'(bus.req_valid && !full_m));
            chk("err", 32'(err), 32'(err_m));
            if (ncap > 0) begin
                chk("rsp_f", 32'(bus.rsp_f), 32'(mq[0].f));
                chk("rsp_func", 32'(bus.rsp_func), 32'(mq[0].func));
            end
`ifdef CORDIC_RSP_QUEUE_STATS_EN
            chk("stat_issued", 32'(stat_issued), 32'(st_iss));
            chk("stat_stall", 32'(stat_stall), 32'(st_stl));
`endif
            fire_m = bus.req_valid && !full_m;
            cap_m  = core_valid && (mq.size() - ncap > 0);
            bad_m  = core_valid && (mq.size() - ncap == 0);
            pop_m  = (ncap > 0) && bus.rsp_ready;
            if (cap_m) ncap++;
            if (pop_m) begin void'(mq.pop_front()); ncap--; end
            if (fire_m) mq.push_back('{func: bus.req_func, f: bus.req_a + 1'b1});
            if (bad_m) err_m = 1;
            if (fire_m) begin n_start++; if (st_iss < 16'hFFFF) st_iss++; end
            if (bus.req_valid && full_m && st_stl < 16'hFFFF) st_stl++;
        end
    end

    task automatic idle(input int n);
        bus.req_valid = 0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    initial begin
        int k, idx, start0;
        bit fired;
        bus.req_valid = 0; bus.req_func = 0; bus.req_a = '0; bus.rsp_ready = 0;
        #12;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1 rst_n = 1;
        idle(2);

        // 1: single ln request, measure latency to rsp_valid
        bus.rsp_ready = 1; bus.req_valid = 1; bus.req_func = 1; bus.req_a = 24'h001000;
        start0 = n_start;
        @(posedge clk); #1 bus.req_valid = 0;
        k = 1;
        while (!bus.rsp_valid && k < 60) begin @(posedge clk); #1 k++; end
        chk("t1_latency", 32'(k), 32'(LAT + 1));
        chk("t1_rsp_f", 32'(bus.rsp_f), 32'h001001);
        chk("t1_rsp_func", 32'(bus.rsp_func), 32'd1);
        chk("t1_starts", 32'(n_start - start0), 32'd1);
        idle(3);

        // 2: eight requests with responses blocked, then drained in order
        bus.rsp_ready = 0; idx = 0; start0 = n_start;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 1; bus.req_func = idx[0]; bus.req_a = DW'(idx);
            @(negedge clk); fired = bus.req_ready;
            @(posedge clk); #1 if (fired) idx++;
        end
        chk("t2_starts_blocked", 32'(n_start - start0), 32'd4);
        chk("t2_ready_low", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1; k = 0;
        while (idx < 8 && k < 200) begin
            bus.req_valid = 1; bus.req_func = idx[0]; bus.req_a = DW'(idx);
            @(negedge clk); fired = bus.req_ready;
            @(posedge clk); #1 if (fired) idx++;
            k++;
        end
        chk("t2_all_issued", 32'(idx), 32'd8);
        idle(LAT + 10);

        // 3: full queue with a pop in the same cycle must not issue
        bus.rsp_ready = 0;
        for (int c = 0; c < DEPTH; c++) begin
            bus.req_valid = 1; bus.req_a = DW'(32'h100 + c); bus.req_func = 0;
            @(posedge clk); #1;
        end
        idle(LAT + 4);
        bus.req_valid = 1; bus.req_a = 24'h000abc; bus.rsp_ready = 1;
        #2 chk("t3_no_start_full", 32'(core_start), 32'd0);
        @(posedge clk); #1 bus.rsp_ready = 0;
        chk("t3_ready_next", 32'(bus.req_ready), 32'd1);
        chk("t3_start_next", 32'(core_start), 32'd1);
        @(posedge clk); #1 bus.req_valid = 0; bus.rsp_ready = 1;
        idle(LAT + 12);

        // 4: spurious core_valid with nothing in flight
        force_cv = 1;
        @(posedge clk); #1 force_cv = 0;
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        idle(3);
        chk("t4_err_sticky", 32'(err), 32'd1);

        // 5: reset with ops in flight and queued
        bus.rsp_ready = 0;
        for (int c = 0; c < 3; c++) begin
            bus.req_valid = 1; bus.req_a = DW'(32'h200 + c);
            @(posedge clk); #1;
        end
        bus.req_valid = 0;
        @(posedge clk); #2 rst_n = 0;
        #1;
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t5_err", 32'(err), 32'd0);
        @(posedge clk); #1 rst_n = 1;
        idle(LAT + 5);
        chk("t5_no_stale", 32'(bus.rsp_valid), 32'd0);

        // Random traffic, checked cycle by cycle against the model
        for (int c = 0; c < 1500; c++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_func  = 1'($urandom);
            bus.req_a     = DW'($urandom);
            bus.rsp_ready = ($urandom_range(0, 2) != 0) || (c % 97 > 80);
            if (c % 200 > 150) bus.rsp_ready = 0;
            @(posedge clk); #1;
        end
        bus.req_valid = 0; bus.rsp_ready = 1;
        idle(LAT + 12);
        chk("drain_empty", 32'(bus.rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
